// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default field widths, ALU logic-unit opcodes,
// the EX/MEM entry layout and the skid buffer state encoding.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_REG_W  = 5;
    localparam int CPU_OP_W   = 4;

    localparam logic [CPU_OP_W-1:0] ALU_AND = 4'b0100;
    localparam logic [CPU_OP_W-1:0] ALU_OR  = 4'b0101;
    localparam logic [CPU_OP_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [CPU_OP_W-1:0] ALU_NOR = 4'b0111;

    typedef struct packed {
        logic [CPU_DATA_W-1:0] result;
        logic [CPU_DATA_W-1:0] store_data;
        logic [CPU_REG_W-1:0]  rd;
        logic [CPU_OP_W-1:0]   alu_op;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  zero;
    } ex_mem_entry_t;

    localparam int EX_MEM_ENTRY_W = $bits(ex_mem_entry_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // True for the four opcodes handled by the ALU logic unit.
    function automatic logic is_logic_op(input logic [CPU_OP_W-1:0] op);
        return (op[CPU_OP_W-1:2] == 2'b01);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_buffer.sv
// Generic 2-entry skid buffer (module skid_buffer): main register drives the
// downstream side, skid register absorbs one overflow entry, ready is registered.
module skid_buffer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    skid_state_t      state;
    logic [WIDTH-1:0] main_p1;
    logic [WIDTH-1:0] skid_p2;
    logic             vld_p1;
    logic             rdy_p1;
    logic             accept;
    logic             drain;

    assign accept = up_valid & rdy_p1;
    assign drain  = vld_p1 & dn_ready;

    // Stage boundary: upstream capture into main/skid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SKID_EMPTY;
            vld_p1  <= 1'b0;
            rdy_p1  <= 1'b1;
            main_p1 <= '0;
            skid_p2 <= '0;
        end else if (flush) begin
            state  <= SKID_EMPTY;
            vld_p1 <= 1'b0;
            rdy_p1 <= 1'b1;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_p1 <= up_data;
                        vld_p1  <= 1'b1;
                        state   <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && !drain) begin
                        skid_p2 <= up_data;
                        rdy_p1  <= 1'b0;
                        state   <= SKID_TWO;
                    end else if (accept && drain) begin
                        main_p1 <= up_data;
                    end else if (drain) begin
                        vld_p1 <= 1'b0;
                        state  <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // Ready is low here, so only a drain can happen.
                    if (drain) begin
                        main_p1 <= skid_p2;
                        rdy_p1  <= 1'b1;
                        state   <= SKID_ONE;
                    end
                end
                default: begin
                    state  <= SKID_EMPTY;
                    vld_p1 <= 1'b0;
                    rdy_p1 <= 1'b1;
                end
            endcase
        end
    end

    assign up_ready = rdy_p1;
    assign dn_valid = vld_p1;
    assign dn_data  = main_p1;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline hand-off: sanitises control at capture, adds a zero flag and
// buffers through a skid buffer. Define EX_MEM_FORWARD_EN to add forwarding taps.
module ex_mem_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_W  = CPU_REG_W,
    parameter int OP_W   = CPU_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [OP_W-1:0]   ex_alu_op,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic [OP_W-1:0]   mem_alu_op,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_zero
`ifdef EX_MEM_FORWARD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic [OP_W-1:0]   alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              zero;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // A load+store combination is illegal: pass it on as a valid bubble.
    function automatic entry_t capture(
        input logic [DATA_W-1:0] result,
        input logic [DATA_W-1:0] store_data,
        input logic [REG_W-1:0]  rd,
        input logic [OP_W-1:0]   alu_op,
        input logic              reg_write,
        input logic              mem_read,
        input logic              mem_write
    );
        entry_t e;
        logic   illegal;
        illegal      = mem_read & mem_write;
        e.result     = result;
        e.store_data = store_data;
        e.rd         = rd;
        e.alu_op     = alu_op;
        e.reg_write  = reg_write & (rd != '0) & ~illegal;
        e.mem_read   = mem_read & ~illegal;
        e.mem_write  = mem_write & ~illegal;
        e.zero       = (result == '0);
        return e;
    endfunction

    entry_t             entry_p0;
    entry_t             entry_p1;
    logic [ENTRY_W-1:0] bits_p0;
    logic [ENTRY_W-1:0] bits_p1;

    assign entry_p0 = capture(ex_result, ex_store_data, ex_rd, ex_alu_op,
                              ex_reg_write, ex_mem_read, ex_mem_write);
    assign bits_p0  = entry_p0;

    // Stage boundary: execute -> memory register.
    skid_buffer #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .up_valid (ex_valid),
        .up_ready (ex_ready),
        .up_data  (bits_p0),
        .dn_valid (mem_valid),
        .dn_ready (mem_ready),
        .dn_data  (bits_p1)
    );

    assign entry_p1       = entry_t'(bits_p1);
    assign mem_result     = entry_p1.result;
    assign mem_store_data = entry_p1.store_data;
    assign mem_rd         = entry_p1.rd;
    assign mem_alu_op     = entry_p1.alu_op;
    assign mem_reg_write  = entry_p1.reg_write;
    assign mem_mem_read   = entry_p1.mem_read;
    assign mem_mem_write  = entry_p1.mem_write;
    assign mem_zero       = entry_p1.zero;

`ifdef EX_MEM_FORWARD_EN
    // Gated by valid so stale main-register data after a flush never forwards.
    assign fwd_valid = mem_valid & entry_p1.reg_write & ~entry_p1.mem_read;
    assign fwd_rd    = mem_valid ? entry_p1.rd : '0;
    assign fwd_data  = mem_valid ? entry_p1.result : '0;
`endif

endmodule
